// File: rtl/donkey_ctl.sv
// Donkey motion controller: turns held keys into sprite position, facing and
// airborne flag, stepping walk / jump / gravity physics once per video frame
// on the rising edge of vsync.
module donkey_ctl #(
  parameter int X_START = 64,
  parameter int Y_START = 640,
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 960,
  parameter int Y_MIN   = 32,
  parameter int Y_FLOOR = 640,
  parameter int STEP    = 4,
  parameter int JUMP_V0 = 16,
  parameter int GRAVITY = 1,
  parameter int V_MAX   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_game,
  input  logic        vsync,
  input  logic        left,
  input  logic        right,
  input  logic        jump,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        rotate,
  output logic        airborne
);

  typedef enum logic [1:0] {IDLE, GROUND, JUMP, FALL} state_t;

  // Position constants widened to 13 bits so arithmetic cannot wrap.
  localparam logic [12:0] X_MIN_W   = 13'(X_MIN);
  localparam logic [12:0] X_MAX_W   = 13'(X_MAX);
  localparam logic [12:0] Y_MIN_W   = 13'(Y_MIN);
  localparam logic [12:0] Y_FLOOR_W = 13'(Y_FLOOR);
  localparam logic [12:0] STEP_W    = 13'(STEP);
  localparam logic [11:0] X_START_W = 12'(X_START);
  localparam logic [11:0] Y_START_W = 12'(Y_START);
  localparam logic [11:0] Y_GND_W   = 12'(Y_FLOOR);
  localparam logic [5:0]  V0_W      = 6'(JUMP_V0);
  localparam logic [5:0]  GRAV_W    = 6'(GRAVITY);
  localparam logic [5:0]  VMAX_W    = 6'(V_MAX);

  state_t      state_reg, state_next;
  logic [5:0]  vel_reg, vel_next;
  logic        vsync_q;
  logic        tick;
  logic [11:0] x_next, y_next;
  logic        rot_next, airborne_next;

  logic [12:0] x_ext, y_ext, vel_ext;
  logic [12:0] x_left, x_right, y_up, y_down;
  logic        ceil_hit, land;
  logic [5:0]  vel_dec, vel_inc;
  logic [6:0]  vel_sum;

  assign tick = vsync & ~vsync_q;

  // Candidate positions and speeds, clamped before they are narrowed back.
  always_comb begin
    x_ext    = {1'b0, xpos};
    y_ext    = {1'b0, ypos};
    vel_ext  = {7'd0, vel_reg};
    // Compare before subtracting so a small xpos never underflows.
    x_left   = (x_ext < X_MIN_W + STEP_W) ? X_MIN_W : x_ext - STEP_W;
    x_right  = (x_ext + STEP_W > X_MAX_W) ? X_MAX_W : x_ext + STEP_W;
    ceil_hit = (y_ext < Y_MIN_W + vel_ext);
    y_up     = ceil_hit ? Y_MIN_W : y_ext - vel_ext;
    y_down   = y_ext + vel_ext;
    land     = (y_down >= Y_FLOOR_W);
    vel_dec  = (vel_reg > GRAV_W) ? vel_reg - GRAV_W : 6'd0;
    vel_sum  = {1'b0, vel_reg} + {1'b0, GRAV_W};
    vel_inc  = (vel_sum > {1'b0, VMAX_W}) ? VMAX_W : vel_sum[5:0];
  end

  // Next-state and next-output logic; start_game low overrides everything.
  always_comb begin
    state_next = state_reg;
    vel_next   = vel_reg;
    x_next     = xpos;
    y_next     = ypos;
    rot_next   = rotate;

    case (state_reg)
      IDLE: begin
        x_next   = X_START_W;
        y_next   = Y_START_W;
        rot_next = 1'b0;
        vel_next = 6'd0;
        if (start_game) state_next = GROUND;
      end
      GROUND: begin
        if (tick && jump) begin
          vel_next   = V0_W;
          state_next = JUMP;
        end
      end
      JUMP: begin
        if (tick) begin
          y_next = y_up[11:0];
          if (vel_dec == 6'd0 || ceil_hit) begin
            vel_next   = 6'd0;
            state_next = FALL;
          end else begin
            vel_next = vel_dec;
          end
        end
      end
      FALL: begin
        if (tick) begin
          if (land) begin
            y_next     = Y_GND_W;
            vel_next   = 6'd0;
            state_next = GROUND;
          end else begin
            y_next   = y_down[11:0];
            vel_next = vel_inc;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Air control: walking applies in every active state.
    if (tick && state_reg != IDLE) begin
      if (left && !right) begin
        x_next   = x_left[11:0];
        rot_next = 1'b1;
      end else if (right && !left) begin
        x_next   = x_right[11:0];
        rot_next = 1'b0;
      end
    end

    if (!start_game) begin
      state_next = IDLE;
      x_next     = X_START_W;
      y_next     = Y_START_W;
      rot_next   = 1'b0;
      vel_next   = 6'd0;
    end

    airborne_next = (state_next == JUMP) || (state_next == FALL);
  end

  // State, physics and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      vel_reg   <= 6'd0;
      vsync_q   <= 1'b0;
      xpos      <= X_START_W;
      ypos      <= Y_START_W;
      rotate    <= 1'b0;
      airborne  <= 1'b0;
    end else begin
      state_reg <= state_next;
      vel_reg   <= vel_next;
      vsync_q   <= vsync;
      xpos      <= x_next;
      ypos      <= y_next;
      rotate    <= rot_next;
      airborne  <= airborne_next;
    end
  end

endmodule

// File: tb/tb_donkey_ctl.sv
// Testbench for donkey_ctl: constant-expectation table and hand sequences on
// two parameterisations, plus an every-cycle comparison against a reference
// model computed from the motion rules with integer arithmetic.
module tb_donkey_ctl;

  logic clk = 1'b0;
  logic rst, start_game, vsync, left, right, jump;
  logic [11:0] xpos_a, ypos_a, xpos_b, ypos_b;
  logic rot_a, air_a, rot_b, air_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  donkey_ctl dut_a (
    .clk(clk), .rst(rst), .start_game(start_game), .vsync(vsync),
    .left(left), .right(right), .jump(jump),
    .xpos(xpos_a), .ypos(ypos_a), .rotate(rot_a), .airborne(air_a)
  );

  donkey_ctl #(.X_START(2), .Y_MIN(600)) dut_b (
    .clk(clk), .rst(rst), .start_game(start_game), .vsync(vsync),
    .left(left), .right(right), .jump(jump),
    .xpos(xpos_b), .ypos(ypos_b), .rotate(rot_b), .airborne(air_b)
  );

  localparam int M_IDLE = 0, M_GROUND = 1, M_JUMP = 2, M_FALL = 3;

  typedef struct {
    int xs; int ys; int xmin; int xmax; int ymin; int yfloor;
    int step; int v0; int g; int vmax;
  } prm_t;

  typedef struct {
    int x; int y; int vel; int mode; bit rot; bit vq;
  } mdl_t;

  typedef struct {
    bit l; bit r; bit j; int n; int ex; int ey; bit erot; bit eair;
  } vec_t;

  prm_t pa, pb;
  mdl_t ma, mb;
  vec_t tbl[13];
  bit   vs_r;

  function automatic mdl_t m_reset(prm_t p);
    mdl_t s;
    s.x = p.xs; s.y = p.ys; s.vel = 0; s.mode = M_IDLE; s.rot = 0; s.vq = 0;
    return s;
  endfunction

  // One clock cycle of the motion rules.
  function automatic mdl_t m_cycle(mdl_t s, prm_t p, bit r_rst, bit sg,
                                   bit vs, bit l, bit r, bit j);
    mdl_t n;
    bit tick;
    int ny, nv;
    bit hit;
    n = s;
    tick = vs && !s.vq;
    if (r_rst) return m_reset(p);
    n.vq = vs;
    if (!sg) begin
      n.x = p.xs; n.y = p.ys; n.vel = 0; n.rot = 0; n.mode = M_IDLE;
      return n;
    end
    if (s.mode == M_IDLE) begin
      n.mode = M_GROUND;
      return n;
    end
    if (!tick) return n;
    if (l && !r) begin
      n.x = s.x - p.step;
      if (n.x < p.xmin) n.x = p.xmin;
      n.rot = 1;
    end else if (r && !l) begin
      n.x = s.x + p.step;
      if (n.x > p.xmax) n.x = p.xmax;
      n.rot = 0;
    end
    if (s.mode == M_GROUND) begin
      if (j) begin
        n.vel = p.v0; n.mode = M_JUMP;
      end
    end else if (s.mode == M_JUMP) begin
      ny  = s.y - s.vel;
      hit = (ny < p.ymin);
      nv  = s.vel - p.g;
      if (nv < 0) nv = 0;
      n.y = hit ? p.ymin : ny;
      if (nv == 0 || hit) begin
        n.vel = 0; n.mode = M_FALL;
      end else begin
        n.vel = nv;
      end
    end else begin
      if (s.y + s.vel >= p.yfloor) begin
        n.y = p.yfloor; n.vel = 0; n.mode = M_GROUND;
      end else begin
        n.y = s.y + s.vel;
        n.vel = (s.vel + p.g > p.vmax) ? p.vmax : s.vel + p.g;
      end
    end
    return n;
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model();
    check("model_a_x", int'(xpos_a), ma.x);
    check("model_a_y", int'(ypos_a), ma.y);
    check("model_a_rot", int'(rot_a), int'(ma.rot));
    check("model_a_air", int'(air_a), int'(ma.mode == M_JUMP || ma.mode == M_FALL));
    check("model_b_x", int'(xpos_b), mb.x);
    check("model_b_y", int'(ypos_b), mb.y);
    check("model_b_rot", int'(rot_b), int'(mb.rot));
    check("model_b_air", int'(air_b), int'(mb.mode == M_JUMP || mb.mode == M_FALL));
  endtask

  // Drive one cycle, advance the model on the edge, compare 1 time unit later.
  task automatic step(bit r_rst, bit sg, bit vs, bit l, bit r, bit j);
    rst = r_rst; start_game = sg; vsync = vs; left = l; right = r; jump = j;
    @(posedge clk);
    ma = m_cycle(ma, pa, r_rst, sg, vs, l, r, j);
    mb = m_cycle(mb, pb, r_rst, sg, vs, l, r, j);
    #1;
    check_model();
  endtask

  task automatic frame(bit l, bit r, bit j);
    repeat (3) step(0, 1, 0, l, r, j);
    repeat (3) step(0, 1, 1, l, r, j);
  endtask

  task automatic check_a(string tag, int ex, int ey, int erot, int eair);
    check({tag, "_x"}, int'(xpos_a), ex);
    check({tag, "_y"}, int'(ypos_a), ey);
    check({tag, "_rot"}, int'(rot_a), erot);
    check({tag, "_air"}, int'(air_a), eair);
  endtask

  initial begin
    pa = '{64, 640, 0, 960, 32, 640, 4, 16, 1, 16};
    pb = '{2, 640, 0, 960, 600, 640, 4, 16, 1, 16};
    ma = m_reset(pa);
    mb = m_reset(pb);

    //          l  r  j  n    x    y    rot air
    tbl[0]  = '{0, 0, 0, 5,   64,  640, 0, 0};
    tbl[1]  = '{0, 1, 0, 1,   68,  640, 0, 0};
    tbl[2]  = '{0, 1, 0, 249, 960, 640, 0, 0};
    tbl[3]  = '{1, 0, 0, 5,   940, 640, 1, 0};
    tbl[4]  = '{1, 1, 0, 3,   940, 640, 1, 0};
    tbl[5]  = '{0, 0, 0, 2,   940, 640, 1, 0};
    tbl[6]  = '{0, 1, 0, 1,   944, 640, 0, 0};
    tbl[7]  = '{0, 0, 1, 1,   944, 640, 0, 1};
    tbl[8]  = '{0, 0, 0, 15,  944, 505, 0, 1};
    tbl[9]  = '{0, 0, 0, 1,   944, 504, 0, 1};
    tbl[10] = '{0, 0, 0, 1,   944, 504, 0, 1};
    tbl[11] = '{0, 0, 0, 15,  944, 624, 0, 1};
    tbl[12] = '{0, 0, 0, 1,   944, 640, 0, 0};

    // Reset state
    repeat (3) step(1, 0, 0, 0, 0, 0);
    check_a("reset_a", 64, 640, 0, 0);
    check("reset_b_x", int'(xpos_b), 2);

    // Walk, clamp, jump arc
    for (int i = 0; i < 13; i++) begin
      repeat (tbl[i].n) frame(tbl[i].l, tbl[i].r, tbl[i].j);
      check_a($sformatf("tbl%0d", i), tbl[i].ex, tbl[i].ey, int'(tbl[i].erot), int'(tbl[i].eair));
    end

    // Held jump re-triggers on the tick after landing
    repeat (34) frame(0, 0, 1);
    check_a("retrig_land", 944, 640, 0, 0);
    frame(0, 0, 1);
    check_a("retrig_jump", 944, 640, 0, 1);
    frame(0, 0, 0);
    check_a("retrig_up", 944, 624, 0, 1);

    // Abort mid-jump: the very next clk returns to the start position
    step(0, 0, 0, 0, 0, 0);
    check_a("abort", 64, 640, 0, 0);

    // Left wall and ceiling on the second instance
    repeat (2) step(1, 0, 0, 0, 0, 0);
    frame(0, 0, 0);
    frame(1, 0, 0);
    check("wall_b_x", int'(xpos_b), 0);
    check("wall_b_rot", int'(rot_b), 1);
    frame(0, 0, 1);
    repeat (3) frame(0, 0, 0);
    check("ceil_b_y", int'(ypos_b), 600);
    frame(0, 0, 0);
    check("ceil_fall_y", int'(ypos_b), 600);
    check("ceil_fall_air", int'(air_b), 1);
    repeat (9) frame(0, 0, 0);
    check("ceil_land_y", int'(ypos_b), 640);
    check("ceil_land_air", int'(air_b), 0);

    // vsync high across reset release gives no tick; a held vsync gives one
    repeat (3) step(1, 1, 1, 0, 1, 0);
    repeat (100) step(0, 1, 1, 0, 1, 0);
    check("vs_rel_x", int'(xpos_a), 64);
    repeat (2) step(0, 1, 0, 0, 1, 0);
    repeat (100) step(0, 1, 1, 0, 1, 0);
    check("vs_hold_x", int'(xpos_a), 68);

    // Randomised stimulus against the model
    vs_r = 0;
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 5) == 0) vs_r = ~vs_r;
      step(bit'($urandom_range(0, 999) == 0), bit'($urandom_range(0, 399) != 0), vs_r,
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
